uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
Serial-to-parallel UART receive front end: 8N1 frames, LSB first, 16x oversampling with a majority-vote bit decision.
Sits directly upstream of the loopback controller and drives its RX_DATA/RX_STATUS inputs.
RX_DATA holds the last good byte. RX_STATUS is a single-sysclk "byte ready" pulse, which the controller latches.

Parameters:
CLK_FREQ, 100000000, sysclk frequency in Hz.
BAUD, 9600, line rate in bit/s.
OVERSAMPLE, 16, ticks per bit; fixed at 16, other values unsupported.
(Derived, not a port parameter) DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer truncation; 651 at defaults.

Ports:
sysclk  input  1  system clock; everything is on its rising edge.
reset  input  1  asynchronous, active-low reset; 0 resets all state immediately.
UART_RX  input  1  asynchronous serial line; idles high.
RX_DATA  output  8  last correctly framed byte; bit0 is the first data bit received.
RX_STATUS  output  1  one-cycle pulse: RX_DATA has just been updated.
FRAME_ERR  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset (reset=0) values:
  - RX_DATA=8'h00, RX_STATUS=0, FRAME_ERR=0.
  - state=IDLE, all counters 0.
  - Synchronizer flops set to 1.
- Input synchronizer: UART_RX passes through 2 flops. The FSM sees only the synchronized value rx_s.
- Tick generator:
  - div_cnt counts 0..DIV-1; tick=1 for one cycle when div_cnt==DIV-1.
  - div_cnt is forced to 0 on the IDLE->START transition, so sampling is aligned to the start edge.
- Per-bit logic:
  - smp_cnt (4 bits) increments on each tick and wraps 15->0.
  - The bit value is the majority of rx_s at ticks where smp_cnt = 7, 8, 9.
  - The decision is made on the tick with smp_cnt==9.
- IDLE:
  - Waits for rx_s falling edge (previous sample 1, current 0).
  - Then go to START, with smp_cnt=0 and div_cnt=0.
- START:
  - At the smp_cnt==9 decision: majority 1 means false start, return to IDLE with no output pulse.
  - Majority 0: continue; at smp_cnt==15 tick go to DATA with bit_idx=0.
- DATA:
  - Each decision shifts the bit into shift_reg[bit_idx] (LSB first).
  - At smp_cnt==15 tick: bit_idx increments; after bit_idx==7 go to STOP.
- STOP, at the smp_cnt==9 decision:
  - Majority 1: RX_DATA<=shift_reg, RX_STATUS=1 for exactly that one cycle, go to IDLE. Ending at mid-stop-bit permits back-to-back frames.
  - Majority 0: FRAME_ERR=1 for one cycle, RX_DATA unchanged, go to BREAK.
- BREAK: stay until rx_s==1, then go to IDLE. A continuous low line therefore yields exactly one FRAME_ERR.
- RX_DATA stability: changes only in the cycle RX_STATUS asserts. It is otherwise held, including through false starts and framing errors.
- RX_STATUS and FRAME_ERR are never both 1 in the same cycle.
- Latency: RX_STATUS rises (2 sync + 1) sysclk cycles after the mid-stop tick, i.e. ~9.6 bit times after the start edge.
- Line edges during DATA/STOP are ignored; only the sample ticks matter.
- Reset mid-frame: immediate return to IDLE. The partial byte is discarded; RX_DATA is cleared to 00.

Test Plan:
Bench uses CLK_FREQ=1600000, BAUD=10000, so DIV=10 and one bit = 160 clocks.
1. Reset released, line high for 2000 clocks -> RX_DATA=00, RX_STATUS and FRAME_ERR never asserted.
2. Send frame 0x5A -> exactly one RX_STATUS pulse ~1530 clocks after the start edge; RX_DATA=0x5A, held until the next frame.
3. Send 0xA5 then 0x3C back-to-back (stop bit 160 clocks) -> two RX_STATUS pulses; RX_DATA=0xA5 then 0x3C.
4. Low glitch of 40 clocks on an idle line -> false start; no pulses; RX_DATA unchanged.
5. Send 0x81 with the stop bit driven low, then line high -> one FRAME_ERR pulse, no RX_STATUS, RX_DATA keeps the previous value. A following good 0x7E frame is received correctly.
6. Single-tick-wide (10-clock) inverted glitch centred at sample 8 of data bit 3 of 0x00 -> majority vote rejects it; RX_DATA=0x00. Separately, assert reset during data bit 4 -> outputs go to reset values within 0 cycles; the next full frame is received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver
// Serial-to-parallel UART receive front end for 8N1 frames, LSB first.
// The line is oversampled 16x and each bit is decided by a majority vote of
// the samples taken at oversample ticks 7, 8 and 9, which sit around mid-bit.
//
// Ports:
//   sysclk    - system clock, all logic on its rising edge
//   reset     - asynchronous, active-low reset
//   UART_RX   - asynchronous serial line, idles high
//   RX_DATA   - last correctly framed byte, bit0 = first data bit received
//   RX_STATUS - one-cycle pulse, RX_DATA has just been updated
//   FRAME_ERR - one-cycle pulse, stop bit was sampled low
module uart_receiver #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       UART_RX,
  output logic [7:0] RX_DATA,
  output logic       RX_STATUS,
  output logic       FRAME_ERR
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t state_q, state_d;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             rx_prev_q, rx_prev_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]       smp_cnt_q, smp_cnt_d;
  logic             smp7_q, smp7_d;
  logic             smp8_q, smp8_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_status_q, rx_status_d;
  logic             frame_err_q, frame_err_d;

  logic rx_s;
  logic tick;
  logic start_edge;
  logic decide;
  logic bit_end;
  logic vote;

  assign rx_s       = sync2_q;
  assign tick       = (div_cnt_q == DIV_LAST);
  assign start_edge = rx_prev_q & ~rx_s;
  assign decide     = tick && (smp_cnt_q == 4'd9);
  assign bit_end    = tick && (smp_cnt_q == 4'd15);
  // Samples 7 and 8 are stored; sample 9 is the live value at the decision tick.
  assign vote       = (smp7_q & smp8_q) | (smp7_q & rx_s) | (smp8_q & rx_s);

  // State and datapath registers. Synchronizer and edge-history flops reset
  // to 1 so an idle-high line does not look like a start edge after reset.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      div_cnt_q   <= '0;
      smp_cnt_q   <= '0;
      smp7_q      <= 1'b0;
      smp8_q      <= 1'b0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_status_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      rx_prev_q   <= rx_prev_d;
      div_cnt_q   <= div_cnt_d;
      smp_cnt_q   <= smp_cnt_d;
      smp7_q      <= smp7_d;
      smp8_q      <= smp8_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_status_q <= rx_status_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic. Leaving STOP at mid-stop-bit gives half a bit of slack
  // so a back-to-back start edge is never missed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_edge) state_d = ST_START;
      ST_START: begin
        if (decide && vote)  state_d = ST_IDLE;
        else if (bit_end)    state_d = ST_DATA;
      end
      ST_DATA:  if (bit_end && (bit_idx_q == 3'd7)) state_d = ST_STOP;
      ST_STOP:  if (decide) state_d = vote ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (rx_s) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and output logic. The divider free-runs but is zeroed on the
  // start edge so every sample tick is phase-aligned to the frame.
  always_comb begin
    sync1_d     = UART_RX;
    sync2_d     = sync1_q;
    rx_prev_d   = sync2_q;
    div_cnt_d   = tick ? '0 : div_cnt_q + DIV_W'(1);
    smp_cnt_d   = smp_cnt_q + {3'b000, tick};
    smp7_d      = (tick && (smp_cnt_q == 4'd7)) ? rx_s : smp7_q;
    smp8_d      = (tick && (smp_cnt_q == 4'd8)) ? rx_s : smp8_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_status_d = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        smp_cnt_d = '0;
        if (start_edge) div_cnt_d = '0;
      end
      ST_START: begin
        if (bit_end) bit_idx_d = '0;
      end
      ST_DATA: begin
        if (decide)  shift_d[bit_idx_q] = vote;
        if (bit_end) bit_idx_d = bit_idx_q + 3'd1;
      end
      ST_STOP: begin
        if (decide) begin
          if (vote) begin
            rx_data_d   = shift_q;
            rx_status_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        smp_cnt_d = '0;
      end
      default: ;
    endcase
  end

  assign RX_DATA   = rx_data_q;
  assign RX_STATUS = rx_status_q;
  assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
// Directed testbench for uart_receiver at DIV = 10 (one bit = 160 clocks).
// Each scenario task drives the serial line and checks its own results.
module tb_uart_receiver;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 10000;
  localparam int BIT      = 160;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       uart_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       frame_err;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int status_cnt = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  int bad_change_cnt = 0;
  int last_status_cyc = 0;
  int frame_start_cyc = 0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] data_log[$];

  uart_receiver #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD(BAUD),
    .OVERSAMPLE(16)
  ) dut (
    .sysclk(sysclk),
    .reset(reset),
    .UART_RX(uart_rx),
    .RX_DATA(rx_data),
    .RX_STATUS(rx_status),
    .FRAME_ERR(frame_err)
  );

  // 100 MHz-style free-running clock.
  always #5 sysclk = ~sysclk;

  // Cycle counter used to measure receive latency.
  always @(posedge sysclk) cyc <= cyc + 1;

  // Output monitor on the falling edge: counts pulses, logs received bytes and
  // flags any RX_DATA change that is not accompanied by RX_STATUS.
  always @(negedge sysclk) begin
    if (rx_status) begin
      status_cnt = status_cnt + 1;
      last_status_cyc = cyc;
      data_log.push_back(rx_data);
    end
    if (frame_err) ferr_cnt = ferr_cnt + 1;
    if (rx_status && frame_err) both_cnt = both_cnt + 1;
    if (reset && (rx_data !== prev_data) && !rx_status) bad_change_cnt = bad_change_cnt + 1;
    prev_data = rx_data;
  end

  // Holds the line high for n clocks.
  task automatic idle(input int n);
    uart_rx = 1'b1;
    repeat (n) @(negedge sysclk);
  endtask

  // Drives one full frame; optionally inverts the line for glitch_len clocks
  // starting glitch_off clocks into frame bit glitch_bit (0 = start bit).
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input int glitch_bit, input int glitch_off, input int glitch_len);
    logic [9:0] frame;
    logic b;
    frame = {stop_bit, data, 1'b0};
    frame_start_cyc = cyc;
    for (int j = 0; j < 10 * BIT; j++) begin
      b = frame[j / BIT];
      if ((j / BIT) == glitch_bit && (j % BIT) >= glitch_off && (j % BIT) < glitch_off + glitch_len)
        b = ~b;
      uart_rx = b;
      @(negedge sysclk);
    end
    uart_rx = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (5) @(negedge sysclk);
    checks++;
    if (rx_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_rx_data actual=%h required=00", rx_data); end
    checks++;
    if (rx_status !== 1'b0) begin failures++; $display("[TB] FAIL reset_rx_status actual=%b required=0", rx_status); end
    checks++;
    if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_err actual=%b required=0", frame_err); end
    reset = 1'b1;
    idle(2000);
    checks++;
    if (rx_data !== 8'h00) begin failures++; $display("[TB] FAIL idle_rx_data actual=%h required=00", rx_data); end
    checks++;
    if (status_cnt !== 0) begin failures++; $display("[TB] FAIL idle_status_pulses actual=%0d required=0", status_cnt); end
    checks++;
    if (ferr_cnt !== 0) begin failures++; $display("[TB] FAIL idle_ferr_pulses actual=%0d required=0", ferr_cnt); end
  endtask

  task automatic test_single_frame();
    int s0;
    int lat;
    s0 = status_cnt;
    send_frame(8'h5A, 1'b1, -1, 0, 0);
    idle(200);
    lat = last_status_cyc - frame_start_cyc;
    checks++;
    if (status_cnt - s0 !== 1) begin failures++; $display("[TB] FAIL single_pulses actual=%0d required=1", status_cnt - s0); end
    checks++;
    if (lat < 1530 || lat > 1556) begin failures++; $display("[TB] FAIL single_latency actual=%0d required=1530..1556", lat); end
    checks++;
    if (rx_data !== 8'h5A) begin failures++; $display("[TB] FAIL single_data actual=%h required=5a", rx_data); end
    idle(500);
    checks++;
    if (rx_data !== 8'h5A) begin failures++; $display("[TB] FAIL single_hold actual=%h required=5a", rx_data); end
  endtask

  task automatic test_back_to_back();
    int s0;
    s0 = status_cnt;
    send_frame(8'hA5, 1'b1, -1, 0, 0);
    send_frame(8'h3C, 1'b1, -1, 0, 0);
    idle(200);
    checks++;
    if (status_cnt - s0 !== 2) begin failures++; $display("[TB] FAIL b2b_pulses actual=%0d required=2", status_cnt - s0); end
    if (data_log.size() >= s0 + 2) begin
      checks++;
      if (data_log[s0] !== 8'hA5) begin failures++; $display("[TB] FAIL b2b_first actual=%h required=a5", data_log[s0]); end
      checks++;
      if (data_log[s0 + 1] !== 8'h3C) begin failures++; $display("[TB] FAIL b2b_second actual=%h required=3c", data_log[s0 + 1]); end
    end
    checks++;
    if (rx_data !== 8'h3C) begin failures++; $display("[TB] FAIL b2b_final actual=%h required=3c", rx_data); end
  endtask

  task automatic test_false_start();
    int s0;
    int f0;
    s0 = status_cnt;
    f0 = ferr_cnt;
    uart_rx = 1'b0;
    repeat (40) @(negedge sysclk);
    idle(2000);
    checks++;
    if (status_cnt - s0 !== 0) begin failures++; $display("[TB] FAIL false_start_status actual=%0d required=0", status_cnt - s0); end
    checks++;
    if (ferr_cnt - f0 !== 0) begin failures++; $display("[TB] FAIL false_start_ferr actual=%0d required=0", ferr_cnt - f0); end
    checks++;
    if (rx_data !== 8'h3C) begin failures++; $display("[TB] FAIL false_start_data actual=%h required=3c", rx_data); end
  endtask

  task automatic test_frame_error();
    int s0;
    int f0;
    s0 = status_cnt;
    f0 = ferr_cnt;
    send_frame(8'h81, 1'b0, -1, 0, 0);
    idle(300);
    checks++;
    if (ferr_cnt - f0 !== 1) begin failures++; $display("[TB] FAIL ferr_pulses actual=%0d required=1", ferr_cnt - f0); end
    checks++;
    if (status_cnt - s0 !== 0) begin failures++; $display("[TB] FAIL ferr_status actual=%0d required=0", status_cnt - s0); end
    checks++;
    if (rx_data !== 8'h3C) begin failures++; $display("[TB] FAIL ferr_data_held actual=%h required=3c", rx_data); end
    // A line held low for several frame times must raise exactly one error.
    uart_rx = 1'b0;
    repeat (3000) @(negedge sysclk);
    idle(300);
    checks++;
    if (ferr_cnt - f0 !== 2) begin failures++; $display("[TB] FAIL break_ferr_pulses actual=%0d required=2", ferr_cnt - f0); end
    checks++;
    if (status_cnt - s0 !== 0) begin failures++; $display("[TB] FAIL break_status actual=%0d required=0", status_cnt - s0); end
    send_frame(8'h7E, 1'b1, -1, 0, 0);
    idle(200);
    checks++;
    if (status_cnt - s0 !== 1) begin failures++; $display("[TB] FAIL recover_pulses actual=%0d required=1", status_cnt - s0); end
    checks++;
    if (rx_data !== 8'h7E) begin failures++; $display("[TB] FAIL recover_data actual=%h required=7e", rx_data); end
  endtask

  task automatic test_glitch_reject();
    int s0;
    s0 = status_cnt;
    // Sample 8 of data bit 3 lands 90 clocks into frame bit 4; invert 85..94.
    send_frame(8'h00, 1'b1, 4, 85, 10);
    idle(200);
    checks++;
    if (status_cnt - s0 !== 1) begin failures++; $display("[TB] FAIL glitch_pulses actual=%0d required=1", status_cnt - s0); end
    checks++;
    if (rx_data !== 8'h00) begin failures++; $display("[TB] FAIL glitch_data actual=%h required=00", rx_data); end
  endtask

  task automatic test_reset_mid_frame();
    int s0;
    logic [9:0] frame;
    send_frame(8'h96, 1'b1, -1, 0, 0);
    idle(200);
    checks++;
    if (rx_data !== 8'h96) begin failures++; $display("[TB] FAIL pre_reset_data actual=%h required=96", rx_data); end
    s0 = status_cnt;
    frame = {1'b1, 8'hFF, 1'b0};
    for (int j = 0; j < 5 * BIT + 80; j++) begin
      uart_rx = frame[j / BIT];
      @(negedge sysclk);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (rx_data !== 8'h00) begin failures++; $display("[TB] FAIL midreset_data actual=%h required=00", rx_data); end
    checks++;
    if (rx_status !== 1'b0) begin failures++; $display("[TB] FAIL midreset_status actual=%b required=0", rx_status); end
    checks++;
    if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL midreset_ferr actual=%b required=0", frame_err); end
    repeat (3) @(negedge sysclk);
    uart_rx = 1'b1;
    reset = 1'b1;
    idle(300);
    checks++;
    if (status_cnt - s0 !== 0) begin failures++; $display("[TB] FAIL midreset_no_pulse actual=%0d required=0", status_cnt - s0); end
    send_frame(8'h4B, 1'b1, -1, 0, 0);
    idle(200);
    checks++;
    if (status_cnt - s0 !== 1) begin failures++; $display("[TB] FAIL post_reset_pulses actual=%0d required=1", status_cnt - s0); end
    checks++;
    if (rx_data !== 8'h4B) begin failures++; $display("[TB] FAIL post_reset_data actual=%h required=4b", rx_data); end
  endtask

  task automatic test_invariants();
    checks++;
    if (both_cnt !== 0) begin failures++; $display("[TB] FAIL status_and_ferr_overlap actual=%0d required=0", both_cnt); end
    checks++;
    if (bad_change_cnt !== 0) begin failures++; $display("[TB] FAIL data_changed_without_status actual=%0d required=0", bad_change_cnt); end
  endtask

  // Scenario sequence; each task leaves the line idle and the DUT in IDLE.
  initial begin
    $display("[TB] starting uart_receiver bench");
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_false_start();
    test_frame_error();
    test_glitch_reject();
    test_reset_mid_frame();
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
